// File: rtl/crc_pkg.sv
// crc_pkg: shared CRC width default, CCITT presets and bit-reverse helper.
package crc_pkg;
  localparam int CRC_DEFAULT_SIZE = 16;
  localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
  localparam logic [15:0] CRC16_CCITT_INIT = 16'hFFFF;
  localparam logic [15:0] CRC16_CCITT_XOR  = 16'h0000;
  // Reverses the low n bits of v; bits at and above n read as zero.
  function automatic logic [63:0] bit_reverse(input logic [63:0] v, input int n);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) if (i < n) r[i] = v[n-1-i];
    return r;
  endfunction
endpackage

// File: rtl/crc_step.sv
// crc_step: combinational one-bit MSB-first LFSR update for an N-bit CRC.
module crc_step #(
  parameter int N = 16
) (
  input  logic [N-1:0] cur,
  input  logic         data,
  input  logic [N-1:0] poly,
  output logic [N-1:0] next_state
);
  assign next_state = {cur[N-2:0], 1'b0} ^ ((cur[N-1] ^ data) ? poly : '0);
endmodule

// File: rtl/crc_dynamic_gen.sv
// crc_dynamic_gen: bit-serial CRC with runtime poly/init/final_xor.
// Define CRC_REFOUT_EN to bit-reverse the register before the final XOR.
module crc_dynamic_gen
  import crc_pkg::*;
#(
  parameter int CRC_SIZE = CRC_DEFAULT_SIZE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                data,
  input  logic                enable,
  input  logic [CRC_SIZE-1:0] init_val,
  input  logic [CRC_SIZE-1:0] poly,
  input  logic [CRC_SIZE-1:0] final_xor,
  output logic [CRC_SIZE-1:0] crc
);
  logic [CRC_SIZE-1:0] state, cur, nxt;
  logic fresh;
  // init_val stands in for the register until the first absorbed bit
  assign cur = fresh ? init_val : state;
  crc_step #(.N(CRC_SIZE)) u_step (
    .cur       (cur),
    .data      (data),
    .poly      (poly),
    .next_state(nxt)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= '0;
      fresh <= 1'b1;
    end else if (enable) begin
      state <= nxt;
      fresh <= 1'b0;
    end
  end
`ifdef CRC_REFOUT_EN
  logic [63:0] rev;
  assign rev = bit_reverse(64'(cur), CRC_SIZE);
  assign crc = rev[CRC_SIZE-1:0] ^ final_xor;
`else
  assign crc = cur ^ final_xor;
`endif
endmodule

// File: tb/tb_crc_dynamic_gen.sv
// tb_crc_dynamic_gen: randomized check of crc_dynamic_gen against a polynomial-division model.
module tb_crc_dynamic_gen;
  import crc_pkg::*;
  typedef bit bitq_t[$];
  logic clk = 1'b0, rst = 1'b0, data = 1'b0, enable = 1'b0;
  logic [15:0] init16, poly16, xor16, crc16, i16;
  logic [7:0] init8, poly8, xor8, crc8, i8;
  int total = 0, bad = 0;
  bitq_t msg;
  always #5 clk = ~clk;
  crc_dynamic_gen #(.CRC_SIZE(16)) u16 (
    .clk(clk), .rst(rst), .data(data), .enable(enable),
    .init_val(init16), .poly(poly16), .final_xor(xor16), .crc(crc16)
  );
  crc_dynamic_gen #(.CRC_SIZE(8)) u8 (
    .clk(clk), .rst(rst), .data(data), .enable(enable),
    .init_val(init8), .poly(poly8), .final_xor(xor8), .crc(crc8)
  );
  // remainder of (M(x)*x^n + init(x)*x^K) mod (x^n + p(x)) by long division
  function automatic logic [63:0] ref_crc(input int n, input logic [63:0] p, input logic [63:0] ini,
                                          input logic [63:0] fx, input bitq_t m);
    bitq_t a;
    logic [63:0] r;
    a = m;
    for (int i = 0; i < n; i++) a.push_back(1'b0);
    for (int i = 0; i < n; i++) a[i] = a[i] ^ ini[n-1-i];
    for (int i = 0; i < m.size(); i++)
      if (a[i]) begin
        a[i] = 1'b0;
        for (int j = 0; j < n; j++) a[i+1+j] = a[i+1+j] ^ p[n-1-j];
      end
    r = '0;
    for (int i = 0; i < n; i++) r[n-1-i] = a[m.size()+i];
`ifdef CRC_REFOUT_EN
    r = bit_reverse(r, n);
`endif
    return (r ^ fx) & ((64'd1 << n) - 64'd1);
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic check_both(input string tag);
    chk({tag, "_16"}, 64'(crc16), ref_crc(16, 64'(poly16), 64'(msg.size() == 0 ? init16 : i16), 64'(xor16), msg));
    chk({tag, "_8"}, 64'(crc8), ref_crc(8, 64'(poly8), 64'(msg.size() == 0 ? init8 : i8), 64'(xor8), msg));
  endtask
  task automatic bit_in(input bit d, input bit e);
    data = d;
    enable = e;
    if (e && msg.size() == 0) begin
      i16 = init16;
      i8 = init8;
    end
    @(posedge clk);
    #1;
    if (e) msg.push_back(d);
    enable = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b0;
    msg.delete();
    #1;
    check_both("rst_async");
    #1;
    rst = 1'b1;
  endtask
  task automatic send_str(input bit gaps);
    logic [7:0] b;
    for (int c = 0; c < 9; c++) begin
      b = 8'h31 + 8'(c);
      for (int k = 7; k >= 0; k--) begin
        bit_in(b[k], 1'b1);
        if (gaps) repeat (3) bit_in(1'($urandom), 1'b0);
      end
    end
  endtask
  initial begin
    init16 = CRC16_CCITT_INIT; poly16 = CRC16_CCITT_POLY; xor16 = CRC16_CCITT_XOR;
    init8 = 8'h00; poly8 = 8'h07; xor8 = 8'h00;
    i16 = init16; i8 = init8;
    repeat (2) @(posedge clk);
    #1;
    chk("reset16", 64'(crc16), 64'hFFFF);
    chk("reset8", 64'(crc8), 64'h00);
    xor16 = 16'h00FF;
    #1;
    chk("reset16_xor", 64'(crc16), 64'hFF00);
    xor16 = CRC16_CCITT_XOR;
    rst = 1'b1;
    send_str(1'b0);
    chk("check16", 64'(crc16), 64'h29B1);
    chk("check8", 64'(crc8), 64'hF4);
    do_reset();
    send_str(1'b1);
    chk("gapped16", 64'(crc16), 64'h29B1);
    chk("gapped8", 64'(crc8), 64'hF4);
    do_reset();
    for (int k = 0; k < 40; k++) bit_in(1'($urandom), 1'b1);
    do_reset();
    send_str(1'b0);
    chk("replay16", 64'(crc16), 64'h29B1);
    do_reset();
    for (int k = 0; k < 20; k++) begin
      bit_in(1'($urandom), 1'b1);
      init16 = 16'($urandom);
      init8 = 8'($urandom);
      check_both("init_late");
    end
    init16 = CRC16_CCITT_INIT; init8 = 8'h00;
    rst = 1'b0;
    msg.delete();
    @(negedge clk);
    rst = 1'b1;
    bit_in(1'b1, 1'b1);
    check_both("rel_same_edge");
    for (int m = 0; m < 7; m++) begin
      if (m >= 2) begin
        poly16 = 16'($urandom); init16 = 16'($urandom); xor16 = 16'($urandom);
        poly8 = 8'($urandom); init8 = 8'($urandom); xor8 = 8'($urandom);
      end
      do_reset();
      for (int k = 0; k < 128; k++) begin
        while ($urandom_range(0, 3) == 0) bit_in(1'($urandom), 1'b0);
        bit_in(m == 0 ? 1'b1 : m == 1 ? 1'b0 : 1'($urandom), 1'b1);
        check_both($sformatf("msg%0d_bit%0d", m, k));
      end
      if (m == 1) chk("zeros_nonzero", 64'(crc16 != 16'h0), 64'd1);
      xor16 = 16'($urandom);
      xor8 = 8'($urandom);
      #1;
      check_both($sformatf("msg%0d_xor", m));
    end
    poly16 = CRC16_CCITT_POLY; xor16 = 16'h0000; init16 = 16'h00FF;
    do_reset();
    #1;
`ifdef CRC_REFOUT_EN
    chk("refout", 64'(crc16), 64'hFF00);
`else
    chk("refout", 64'(crc16), 64'h00FF);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
